// File: rtl/cond_commit.sv
// cond_commit: evaluates the ARM condition against the committed NZCV flags,
// gates reg/mem/PC writes, commits ALU flags under FlagW, and presents the
// result through one registered valid/ready stage.
// Latency: 1 cycle from Accept to out_valid; full throughput with out_ready=1.
// Backpressure: while out_valid & ~out_ready the output stage and all
// architectural state hold, and in_ready is low.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready: upstream handshake.
//   Cond, FlagW, ALUFlags, Result, WA3, RegW, MemW, PCS: instruction from execute.
//   flush: kills the held output and any input offered that cycle.
//   out_*: registered writeback payload; out_valid/out_ready handshake.
//   Flags: committed {N,Z,C,V}; squash_count: wrapping count of squashed accepts.
module cond_commit #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         Cond,
  input  logic [1:0]         FlagW,
  input  logic [3:0]         ALUFlags,
  input  logic [DATA_W-1:0]  Result,
  input  logic [RADDR_W-1:0] WA3,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               PCS,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_Result,
  output logic [RADDR_W-1:0] out_WA3,
  output logic               out_RegWrite,
  output logic               out_MemWrite,
  output logic               out_PCSrc,
  output logic               out_CondEx,
  output logic [3:0]         Flags,
  output logic [15:0]        squash_count
);

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_result_q, out_result_d;
  logic [RADDR_W-1:0] out_wa3_q, out_wa3_d;
  logic               out_regw_q, out_regw_d;
  logic               out_memw_q, out_memw_d;
  logic               out_pcsrc_q, out_pcsrc_d;
  logic               out_condex_q, out_condex_d;
  logic [3:0]         flags_q, flags_d;
  logic [15:0]        squash_count_q, squash_count_d;

  logic cond_ex;
  logic accept;
  logic flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // in_ready must not depend on in_valid, so it only looks at the output stage.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  // Condition is judged against committed flags, so a flag-setting op
  // immediately followed by a conditional op sees the new value without stall.
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'h0: cond_ex = flag_z;
      4'h1: cond_ex = ~flag_z;
      4'h2: cond_ex = flag_c;
      4'h3: cond_ex = ~flag_c;
      4'h4: cond_ex = flag_n;
      4'h5: cond_ex = ~flag_n;
      4'h6: cond_ex = flag_v;
      4'h7: cond_ex = ~flag_v;
      4'h8: cond_ex = flag_c & ~flag_z;
      4'h9: cond_ex = ~flag_c | flag_z;
      4'hA: cond_ex = (flag_n == flag_v);
      4'hB: cond_ex = (flag_n != flag_v);
      4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
      4'hD: cond_ex = flag_z | (flag_n != flag_v);
      4'hE: cond_ex = 1'b1;
      4'hF: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_wa3_d      = out_wa3_q;
    out_regw_d     = out_regw_q;
    out_memw_d     = out_memw_q;
    out_pcsrc_d    = out_pcsrc_q;
    out_condex_d   = out_condex_q;
    flags_d        = flags_q;
    squash_count_d = squash_count_q;

    if (flush) begin
      // Flush beats Accept: payload registers keep stale data behind valid=0.
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = Result;
      out_wa3_d    = WA3;
      out_regw_d   = RegW & cond_ex;
      out_memw_d   = MemW & cond_ex;
      out_pcsrc_d  = PCS & cond_ex;
      out_condex_d = cond_ex;
      if (cond_ex) begin
        if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
      end else begin
        squash_count_d = squash_count_q + 16'd1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_wa3_q      <= '0;
      out_regw_q     <= 1'b0;
      out_memw_q     <= 1'b0;
      out_pcsrc_q    <= 1'b0;
      out_condex_q   <= 1'b0;
      flags_q        <= 4'b0000;
      squash_count_q <= 16'd0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_wa3_q      <= out_wa3_d;
      out_regw_q     <= out_regw_d;
      out_memw_q     <= out_memw_d;
      out_pcsrc_q    <= out_pcsrc_d;
      out_condex_q   <= out_condex_d;
      flags_q        <= flags_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_Result   = out_result_q;
  assign out_WA3      = out_wa3_q;
  assign out_RegWrite = out_regw_q;
  assign out_MemWrite = out_memw_q;
  assign out_PCSrc    = out_pcsrc_q;
  assign out_CondEx   = out_condex_q;
  assign Flags        = flags_q;
  assign squash_count = squash_count_q;

endmodule

// File: tb/tb_cond_commit.sv
module tb_cond_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Cond;
  logic [1:0]  FlagW;
  logic [3:0]  ALUFlags;
  logic [31:0] Result;
  logic [3:0]  WA3;
  logic        RegW, MemW, PCS;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_Result;
  logic [3:0]  out_WA3;
  logic        out_RegWrite, out_MemWrite, out_PCSrc, out_CondEx;
  logic [3:0]  Flags;
  logic [15:0] squash_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cond_commit #(.DATA_W(32), .RADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Cond(Cond), .FlagW(FlagW), .ALUFlags(ALUFlags), .Result(Result), .WA3(WA3),
    .RegW(RegW), .MemW(MemW), .PCS(PCS), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Result(out_Result), .out_WA3(out_WA3),
    .out_RegWrite(out_RegWrite), .out_MemWrite(out_MemWrite), .out_PCSrc(out_PCSrc),
    .out_CondEx(out_CondEx), .Flags(Flags), .squash_count(squash_count)
  );

  typedef struct {
    logic        v, fl, ordy;
    logic [3:0]  cond;
    logic [1:0]  fw;
    logic [3:0]  af;
    logic [31:0] res;
    logic        rw, mw, ps;
    logic        e_ov, e_rw, e_mw, e_pc, e_cx;
    logic [3:0]  e_flags;
    logic [15:0] e_sq;
    logic [31:0] e_res;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic v, input logic fl, input logic ordy, input logic [3:0] cond,
    input logic [1:0] fw, input logic [3:0] af, input logic [31:0] res,
    input logic rw, input logic mw, input logic ps,
    input logic e_ov, input logic e_rw, input logic e_mw, input logic e_pc,
    input logic e_cx, input logic [3:0] e_flags, input logic [15:0] e_sq,
    input logic [31:0] e_res);
    vec_t t;
    t.v = v; t.fl = fl; t.ordy = ordy; t.cond = cond; t.fw = fw; t.af = af;
    t.res = res; t.rw = rw; t.mw = mw; t.ps = ps;
    t.e_ov = e_ov; t.e_rw = e_rw; t.e_mw = e_mw; t.e_pc = e_pc; t.e_cx = e_cx;
    t.e_flags = e_flags; t.e_sq = e_sq; t.e_res = e_res;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic ordy,
                       input logic [3:0] cond, input logic [1:0] fw,
                       input logic [3:0] af, input logic [31:0] res,
                       input logic rw, input logic mw, input logic ps);
    in_valid = v; flush = fl; out_ready = ordy; Cond = cond; FlagW = fw;
    ALUFlags = af; Result = res; WA3 = res[3:0]; RegW = rw; MemW = mw; PCS = ps;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic rw,
                           input logic mw, input logic pc, input logic cx,
                           input logic [3:0] fl, input logic [15:0] sq,
                           input logic [31:0] res);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out_RegWrite"}, {31'd0, out_RegWrite}, {31'd0, rw});
    chk({tag, ".out_MemWrite"}, {31'd0, out_MemWrite}, {31'd0, mw});
    chk({tag, ".out_PCSrc"}, {31'd0, out_PCSrc}, {31'd0, pc});
    chk({tag, ".out_CondEx"}, {31'd0, out_CondEx}, {31'd0, cx});
    chk({tag, ".Flags"}, {28'd0, Flags}, {28'd0, fl});
    chk({tag, ".squash_count"}, {16'd0, squash_count}, {16'd0, sq});
    chk({tag, ".out_Result"}, out_Result, res);
    chk({tag, ".out_WA3"}, {28'd0, out_WA3}, {28'd0, res[3:0]});
  endtask

  initial begin
    //        v fl rdy cond fw  af    res     rw mw ps | ov rw mw pc cx flags sq res
    tbl.push_back(mk(1,0,1,4'hE,2'd3,4'h4,32'h11,0,0,0, 1,0,0,0,1,4'h4,16'd0,32'h11)); // CMP sets Z
    tbl.push_back(mk(1,0,1,4'h0,2'd0,4'h0,32'h12,0,0,1, 1,0,0,1,1,4'h4,16'd0,32'h12)); // BEQ taken
    tbl.push_back(mk(1,0,1,4'h1,2'd3,4'h8,32'h13,1,1,0, 1,0,0,0,0,4'h4,16'd1,32'h13)); // NE squash
    tbl.push_back(mk(1,0,1,4'hF,2'd0,4'h0,32'h14,1,0,0, 1,0,0,0,0,4'h4,16'd2,32'h14)); // reserved
    tbl.push_back(mk(1,0,1,4'h8,2'd0,4'h0,32'h15,1,0,0, 1,0,0,0,0,4'h4,16'd3,32'h15)); // HI false
    tbl.push_back(mk(1,0,1,4'h9,2'd0,4'h0,32'h16,1,0,0, 1,1,0,0,1,4'h4,16'd3,32'h16)); // LS true
    tbl.push_back(mk(1,0,1,4'hE,2'd2,4'hB,32'h17,0,0,0, 1,0,0,0,1,4'h8,16'd3,32'h17)); // NZ only
    tbl.push_back(mk(1,0,1,4'hE,2'd1,4'h3,32'h18,0,0,0, 1,0,0,0,1,4'hB,16'd3,32'h18)); // CV only
    tbl.push_back(mk(1,0,1,4'hA,2'd0,4'h0,32'h19,1,0,0, 1,1,0,0,1,4'hB,16'd3,32'h19)); // GE
    tbl.push_back(mk(1,0,1,4'hB,2'd3,4'h0,32'h1A,1,0,0, 1,0,0,0,0,4'hB,16'd4,32'h1A)); // LT, no flag write
    tbl.push_back(mk(1,0,1,4'hC,2'd0,4'h0,32'h1B,0,1,0, 1,0,1,0,1,4'hB,16'd4,32'h1B)); // GT
    tbl.push_back(mk(1,0,1,4'hD,2'd0,4'h0,32'h1C,0,1,0, 1,0,0,0,0,4'hB,16'd5,32'h1C)); // LE
    tbl.push_back(mk(1,0,1,4'h4,2'd0,4'h0,32'h1D,0,0,1, 1,0,0,1,1,4'hB,16'd5,32'h1D)); // MI
    tbl.push_back(mk(1,0,1,4'h5,2'd0,4'h0,32'h1E,0,0,1, 1,0,0,0,0,4'hB,16'd6,32'h1E)); // PL
    tbl.push_back(mk(1,0,1,4'h2,2'd0,4'h0,32'h1F,1,0,0, 1,1,0,0,1,4'hB,16'd6,32'h1F)); // CS
    tbl.push_back(mk(1,0,1,4'h3,2'd0,4'h0,32'h20,1,0,0, 1,0,0,0,0,4'hB,16'd7,32'h20)); // CC
    tbl.push_back(mk(1,0,1,4'h6,2'd0,4'h0,32'h21,1,0,0, 1,1,0,0,1,4'hB,16'd7,32'h21)); // VS
    tbl.push_back(mk(1,0,1,4'h7,2'd0,4'h0,32'h22,1,0,0, 1,0,0,0,0,4'hB,16'd8,32'h22)); // VC
    tbl.push_back(mk(1,0,1,4'h1,2'd0,4'h0,32'h23,1,0,0, 1,1,0,0,1,4'hB,16'd8,32'h23)); // NE true
    tbl.push_back(mk(1,1,1,4'hE,2'd3,4'h0,32'h24,1,0,0, 0,1,0,0,1,4'hB,16'd8,32'h23)); // flush
    tbl.push_back(mk(0,0,1,4'hE,2'd3,4'h0,32'h99,0,0,0, 0,1,0,0,1,4'hB,16'd8,32'h23)); // idle
    tbl.push_back(mk(1,0,1,4'h0,2'd0,4'h0,32'h25,1,0,0, 1,0,0,0,0,4'hB,16'd9,32'h25)); // EQ false
    tbl.push_back(mk(0,0,1,4'h0,2'd0,4'h0,32'h26,0,0,0, 0,0,0,0,0,4'hB,16'd9,32'h25)); // drain

    reset = 1'b1;
    drive(0,0,1,4'h0,2'd0,4'h0,32'h0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", 0,0,0,0,0,4'h0,16'd0,32'h0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].fl, tbl[i].ordy, tbl[i].cond, tbl[i].fw, tbl[i].af,
            tbl[i].res, tbl[i].rw, tbl[i].mw, tbl[i].ps);
      #1 chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_rw, tbl[i].e_mw,
                tbl[i].e_pc, tbl[i].e_cx, tbl[i].e_flags, tbl[i].e_sq, tbl[i].e_res);
    end

    // Backpressure: A accepted into a stalled stage, B waits three cycles.
    @(negedge clk);
    drive(1,0,0,4'hE,2'd3,4'h1,32'hA0,0,0,0);
    #1 chk("bp.a.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_out("bp.a", 1,0,0,0,1,4'h1,16'd9,32'hA0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1,0,0,4'hE,2'd3,4'h2,32'hB0,1,0,0);
      #1 chk($sformatf("bp.stall%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check_out($sformatf("bp.stall%0d", k), 1,0,0,0,1,4'h1,16'd9,32'hA0);
    end
    @(negedge clk);
    drive(1,0,1,4'hE,2'd3,4'h2,32'hB0,1,0,0);
    #1 chk("bp.b.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_out("bp.b", 1,1,0,0,1,4'h2,16'd9,32'hB0);
    @(negedge clk);
    drive(0,0,1,4'hE,2'd0,4'h0,32'h0,0,0,0);
    @(posedge clk); #1;
    check_out("bp.drain", 0,1,0,0,1,4'h2,16'd9,32'hB0);

    // Reset while a held output is stalled.
    @(negedge clk);
    drive(1,0,0,4'hE,2'd3,4'hA,32'hC0,1,1,1);
    @(posedge clk); #1;
    check_out("rst.pre", 1,1,1,1,1,4'hA,16'd9,32'hC0);
    @(negedge clk);
    reset = 1'b1;
    drive(1,1,0,4'hE,2'd3,4'h5,32'hC1,1,1,1);
    @(posedge clk); #1;
    check_out("rst.mid", 0,0,0,0,0,4'h0,16'd0,32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1,0,1,4'hE,2'd3,4'h4,32'hD0,1,0,0);
    #1 chk("rst.post.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_out("rst.post", 1,1,0,0,1,4'h4,16'd0,32'hD0);
    @(negedge clk);
    drive(1,0,1,4'h0,2'd0,4'h0,32'hD1,0,0,1);
    @(posedge clk); #1;
    check_out("rst.beq", 1,0,0,1,1,4'h4,16'd0,32'hD1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_commit.md
# cond_commit

Condition-evaluation and flag-commit stage that consumes the ALU's `Result` and `ALUFlags` (N,Z,C,V) and owns the architectural NZCV flag register. It evaluates the instruction's 4-bit ARM condition against the committed flags. It gates register, memory and PC writes, and updates the flags under `FlagW`. Results are presented to writeback through one registered valid/ready stage. It sits between the execute-stage ALU and the writeback/memory stage.

## Interface
Parameters:
- DATA_W, 32, width of result path
- RADDR_W, 4, width of destination register address

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; `= ~out_valid | out_ready`
- Cond  in  4  ARM condition field
- FlagW  in  2  [1] writes N,Z; [0] writes C,V
- ALUFlags  in  4  {N,Z,C,V} from the ALU, bit 3 = N
- Result  in  DATA_W  ALU result
- WA3  in  RADDR_W  destination register
- RegW, MemW, PCS  in  1 each  unconditioned write/branch requests
- flush  in  1  kill the held output and the current input transfer
- out_valid  out  1  registered output valid
- out_ready  in  1  downstream accepts
- out_Result  out  DATA_W  registered result
- out_WA3  out  RADDR_W  registered destination
- out_RegWrite, out_MemWrite, out_PCSrc  out  1 each  requests ANDed with CondEx
- out_CondEx  out  1  condition outcome of the held instruction
- Flags  out  4  committed {N,Z,C,V}
- squash_count  out  16  count of accepted instructions with CondEx=0; wraps

## Operation
- Accept = in_valid & in_ready & ~flush.
- CondEx is evaluated combinationally from the `Flags` register, never from `ALUFlags`.
- Cond mapping:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F reserved, evaluates 0
- On Accept:
  - output registers load.
  - out_RegWrite = RegW&CondEx; out_MemWrite = MemW&CondEx; out_PCSrc = PCS&CondEx.
  - out_Result and out_WA3 load unconditionally.
  - If CondEx=1: Flags[3:2] <= ALUFlags[3:2] when FlagW[1]; Flags[1:0] <= ALUFlags[1:0] when FlagW[0].
  - If CondEx=0: Flags unchanged; squash_count increments, wrapping FFFF→0000.
- Held output: while out_valid & ~out_ready, all out_* registers hold and in_ready=0.
- Output handshake: out_valid & out_ready with no Accept → out_valid <= 0.
- Flush: out_valid <= 0 next edge. An input presented that cycle is dropped, with no flag or counter update. Flush dominates Accept.
- The ALU decoder clears FlagW[0] for logic ops. This block captures whatever ALUFlags holds under FlagW.

## Timing
- Latency is 1 cycle, Accept edge to out_valid. Throughput is 1 instruction/cycle with zero bubbles under out_ready=1.
- Flags update on the same edge as Accept. The next instruction's CondEx sees the new flags, so CMP followed by BEQ needs no stall.
- in_ready is combinational from out_valid and out_ready only. It does not depend on in_valid.
- Reset (any cycle, including mid-stall):
  - out_valid=0, Flags=0000, squash_count=0.
  - out_Result=0, out_WA3=0, all out_* write enables 0, out_CondEx=0.
  - A held output is discarded.
  - Reset dominates flush and Accept.

## Test plan
- CMP then branch: CMP with ALUFlags=0100, FlagW=11, Cond=E, then next cycle Cond=0, PCS=1 → Flags=0100 after the first edge; second output has out_PCSrc=1, out_CondEx=1.
- Squash and count: Flags=0000, Cond=0, RegW=1, FlagW=11, ALUFlags=1000 → out_RegWrite=0, Flags stays 0000, squash_count=1. Cond=F → also squashed, squash_count=2.
- Partial flag write: Flags=0000, FlagW=10, ALUFlags=1111, Cond=E → Flags=1100. Then FlagW=01 with ALUFlags=0011 → Flags=1111.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0; outputs, Flags and squash_count frozen; out_ready=1 → transfers in order, no loss or duplication.
- Flush: flush=1 with out_valid=1 and in_valid=1 (Cond=E, FlagW=11) → next cycle out_valid=0, Flags unchanged.
- Reset mid-stall: out_valid=1, out_ready=0, Flags=1010, reset=1 for 1 cycle → all outputs at reset values; the first post-reset Accept behaves normally.
